// File: rtl/uart_tx_pkg.sv
// Shared UART transmit types: FSM state encoding and parity helper.
`include "uart_globals.svh"

package uart_tx_pkg;

  localparam int unsigned NumDataBits = `NUM_DATA_BITS;

  // Encoding is shared with the receiver and the debug/LED logic.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [NumDataBits-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_globals.svh
// Shared UART constants used by the transmitter, receiver and debug logic.
`ifndef UART_GLOBALS_SVH
`define UART_GLOBALS_SVH

`define NUM_DATA_BITS 8
`define CLK_FRQ 50_000_000
`define BAUD_RATE_TX 115200

`endif

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth, head is read combinationally.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Requests are ignored when they cannot be honoured, so no overflow/underflow.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset flushes the FIFO.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data (LSB first), even parity, stop.
`include "uart_globals.svh"

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FRQ    = `CLK_FRQ,
  parameter int unsigned BAUD_RATE  = `BAUD_RATE_TX,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          cts,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FRQ / BAUD_RATE;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit = 3'(NumDataBits - 1);

  tx_state_t        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cts_meta_q, cts_s_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             bit_end, launch;

  assign ready     = !fifo_full;
  assign fifo_push = valid && ready;

  // A bit time ends on the last baud count of any non-idle state.
  assign bit_end = (baud_q == BaudLast);

  // CTS is only looked at in IDLE and at the end of STOP, so a frame is never cut short.
  assign launch   = !fifo_empty && !cts_s_q &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign fifo_pop = launch;

  uart_tx_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (fifo_push),
    .wdata_i (data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Two-flop synchroniser for the asynchronous active-low CTS; resets to "not clear".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts;
      cts_s_q    <= cts_meta_q;
    end
  end

  // State register: FSM state, baud/bit counters, shifter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: each non-idle state holds for one full bit time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_q == LastBit)) state_d = PARITY;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = launch ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values; tx_d is the level for the coming bit time.
  always_comb begin
    baud_d   = ((state_q == IDLE) || bit_end) ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      START: begin
        if (bit_end) begin
          tx_d  = shift_q[0];
          bit_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LastBit) begin
            tx_d = parity_q;
          end else begin
            // Shift out the sent bit; the next one is what lands in shift[0].
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) tx_d = 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Loading a new byte overrides the above so back-to-back frames have no idle gap.
    if (launch) begin
      shift_d  = fifo_rdata;
      parity_d = even_parity(fifo_rdata);
      tx_d     = 1'b0;
      busy_d   = 1'b1;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit, with a line decoder as reference.
module tb_uart_tx;

  localparam int unsigned CPB = 16;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data;
  logic          valid;
  logic          cts;
  logic          ready, tx, busy, done;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic       ok;
  } frame_t;

  logic [7:0] exp_q[$];
  frame_t     rx_q[$];

  uart_tx #(
    .CLK_FRQ    (16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .cts        (cts),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Line decoder: on a low level after idle, sample mid-bit for 11 bits; abort on reset.
  always begin : line_monitor
    logic [10:0] bits;
    logic        abort;
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      bits  = '0;
      abort = 1'b0;
      for (int n = 1; n <= 168; n++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          abort = 1'b1;
          break;
        end
        if (n % 16 == 8) bits[n/16] = tx;
      end
      if (!abort) begin
        rx_q.push_back('{d: bits[8:1],
                         ok: (bits[0] == 1'b0) && (bits[10] == 1'b1) &&
                             (bits[9] == ^bits[8:1])});
      end
    end
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer a byte at a negedge; returns at the negedge after it was accepted.
  task automatic push_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    valid = 1'b1;
    data  = b;
    while (ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: ready=%b want 1 within 3000 cycles", ready);
      valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    valid = 1'b0;
    exp_q.push_back(b);
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; data = '0; cts = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_checks++;
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
  endtask

  // One frame, checked bit by bit plus latency, done timing and busy release.
  task automatic test_frame(input logic [7:0] b);
    logic [10:0] exp_bits;
    bit ok;
    exp_bits = {1'b1, ^b, b, 1'b0};
    rx_q.delete(); exp_q.delete();
    push_byte(b, ok);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL lat_early: tx=%b want 1", tx); end
    n_checks++;
    if (fifo_count !== 4'd1) begin
      n_fail++; $display("FAIL lat_count: got %0d want 1", fifo_count);
    end
    @(negedge clk);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL lat_fall: tx=%b want 0", tx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", busy); end
    for (int n = 1; n <= 177; n++) begin
      @(negedge clk);
      if (n % 16 == 8 && n <= 168) begin
        n_checks++;
        if (tx !== exp_bits[n/16]) begin
          n_fail++;
          $display("FAIL frame_bit%0d byte %02h: got %b want %b", n/16, b, tx, exp_bits[n/16]);
        end
      end
      if (n == 175 || n == 177) begin
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_early_late n=%0d: got %b want 0", n, done); end
      end
      if (n == 176) begin
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b want 1", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_release: got %b want 0", busy); end
      end
    end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0].d !== b || rx_q[0].ok !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_decode: got %0d frames want 1 frame of %02h", rx_q.size(), b);
    end
  endtask

  // Queue 8 bytes with CTS held off, then release for a gapless burst.
  task automatic test_back_to_back();
    bit ok;
    bit tx_low;
    int nd, gaps, t;
    cts = 1'b1;
    repeat (4) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    for (int i = 1; i <= 8; i++) push_byte(8'(i), ok);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ready); end
    n_checks++;
    if (fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL full_count: got %0d want 8", fifo_count);
    end
    tx_low = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    n_checks++; if (tx_low) begin n_fail++; $display("FAIL cts_hold: tx went low, want 1"); end
    cts = 1'b0;
    t = 0;
    while (busy !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    nd = 0; gaps = 0; t = 0;
    while (nd < 8 && t < 8 * 176 + 20) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) nd++;
      else if (busy !== 1'b1) gaps++;
    end
    n_checks++; if (nd != 8) begin n_fail++; $display("FAIL burst_done: got %0d want 8", nd); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL burst_gap: got %0d want 0", gaps); end
    n_checks++;
    if (rx_q.size() != 8) begin n_fail++; $display("FAIL burst_size: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      n_checks++;
      if (rx_q[i].d !== exp_q[i] || rx_q[i].ok !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_byte%0d: got %02h ok=%b want %02h ok=1", i, rx_q[i].d, rx_q[i].ok, exp_q[i]);
      end
    end
  endtask

  // Raise CTS mid-frame: the frame completes, the next one waits for CTS to drop.
  task automatic test_cts_midframe();
    bit ok, bad;
    int t, k;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    rx_q.delete(); exp_q.delete();
    cts = 1'b0;
    push_byte(b1, ok);
    push_byte(b2, ok);
    repeat (70) @(negedge clk);
    cts = 1'b1;
    t = 0;
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL mid_hold: tx/busy/count moved, want 1/0/1"); end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0].d !== b1 || rx_q[0].ok !== 1'b1) begin
      n_fail++; $display("FAIL mid_first: got %0d frames want 1 of %02h", rx_q.size(), b1);
    end
    cts = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (tx !== 1'b0 && k < 10);
    n_checks++; if (k != 3) begin n_fail++; $display("FAIL cts_latency: got %0d want 3", k); end
    t = 0;
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_checks++;
    if (rx_q.size() != 2 || rx_q[1].d !== b2 || rx_q[1].ok !== 1'b1) begin
      n_fail++; $display("FAIL mid_second: got %0d frames want 2, last %02h", rx_q.size(), b2);
    end
  endtask

  // Asynchronous reset during DATA flushes everything; the link works afterwards.
  task automatic test_reset_midframe();
    bit ok, bad;
    int t;
    logic [7:0] b3;
    exp_q.delete();
    cts = 1'b0;
    push_byte(8'h3C, ok);
    push_byte(8'hC3, ok);
    repeat (40) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL arst_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", ready); end
    n_checks++;
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL arst_count: got %0d want 0", fifo_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_q.delete(); exp_q.delete();
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL post_reset_idle: line active, want idle"); end
    b3 = 8'($urandom);
    push_byte(b3, ok);
    t = 0;
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0].d !== b3 || rx_q[0].ok !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_frame: got %0d frames want 1 of %02h", rx_q.size(), b3);
    end
  endtask

  // 200 random bytes with random producer gaps and CTS toggling, scoreboarded in order.
  task automatic test_random();
    bit ok;
    bit prod_done;
    int t;
    rx_q.delete(); exp_q.delete();
    cts = 1'b0;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 12)) @(negedge clk);
          push_byte(8'($urandom), ok);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          repeat ($urandom_range(50, 400)) @(negedge clk);
          cts = 1'b1;
          repeat ($urandom_range(1, 60)) @(negedge clk);
          cts = 1'b0;
        end
      end
    join
    cts = 1'b0;
    t = 0;
    while (rx_q.size() < exp_q.size() && t < 4000) begin @(negedge clk); t++; end
    n_checks++;
    if (rx_q.size() != exp_q.size() || exp_q.size() != 200) begin
      n_fail++;
      $display("FAIL rand_count: got %0d frames want %0d (200 pushed)", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i].d !== exp_q[i] || rx_q[i].ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_byte%0d: got %02h ok=%b want %02h ok=1", i, rx_q[i].d, rx_q[i].ok, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_frame(8'h00);
    test_back_to_back();
    test_cts_midframe();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
